// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: opcodes, condition codes, PC select
// encodings, sequencer states and PSR flag bit positions.
package cpu_pkg;

   localparam logic [3:0] OP_BCOND  = 4'hC;
   localparam logic [3:0] OP_EXT    = 4'h4;
   localparam logic [3:0] EXT_JCOND = 4'hC;
   localparam logic [3:0] EXT_JAL   = 4'h8;

   localparam logic [3:0] CC_EQ = 4'h0;
   localparam logic [3:0] CC_NE = 4'h1;
   localparam logic [3:0] CC_CS = 4'h2;
   localparam logic [3:0] CC_CC = 4'h3;
   localparam logic [3:0] CC_HI = 4'h4;
   localparam logic [3:0] CC_LS = 4'h5;
   localparam logic [3:0] CC_GT = 4'h6;
   localparam logic [3:0] CC_LE = 4'h7;
   localparam logic [3:0] CC_FS = 4'h8;
   localparam logic [3:0] CC_FC = 4'h9;
   localparam logic [3:0] CC_LO = 4'hA;
   localparam logic [3:0] CC_HS = 4'hB;
   localparam logic [3:0] CC_LT = 4'hC;
   localparam logic [3:0] CC_GE = 4'hD;
   localparam logic [3:0] CC_UC = 4'hE;

   localparam logic [1:0] SEL_DEFAULT = 2'b00;
   localparam logic [1:0] SEL_IMM     = 2'b01;
   localparam logic [1:0] SEL_MEM     = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      ADV   = 2'd3
   } seq_state_e;

   // PSR layout {C,L,F,Z,N}
   localparam int unsigned FLAG_N = 0;
   localparam int unsigned FLAG_Z = 1;
   localparam int unsigned FLAG_F = 2;
   localparam int unsigned FLAG_L = 3;
   localparam int unsigned FLAG_C = 4;

endpackage

// File: rtl/cond_eval.sv
// Condition-code evaluator: decides whether a 4-bit condition holds for the
// current PSR flags. Shared by branch resolution and the ALU's Scond.
module cond_eval
   import cpu_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [4:0] flags,
   output logic       taken
);

   // Map each condition code onto its flag predicate; 1111 never holds
   always_comb begin
      taken = 1'b0;
      case (cond)
         CC_EQ:   taken =  flags[FLAG_Z];
         CC_NE:   taken = !flags[FLAG_Z];
         CC_CS:   taken =  flags[FLAG_C];
         CC_CC:   taken = !flags[FLAG_C];
         CC_HI:   taken =  flags[FLAG_L];
         CC_LS:   taken = !flags[FLAG_L];
         CC_GT:   taken =  flags[FLAG_N];
         CC_LE:   taken = !flags[FLAG_N];
         CC_FS:   taken =  flags[FLAG_F];
         CC_FC:   taken = !flags[FLAG_F];
         CC_LO:   taken = !flags[FLAG_L] && !flags[FLAG_Z];
         CC_HS:   taken =  flags[FLAG_L] ||  flags[FLAG_Z];
         CC_LT:   taken = !flags[FLAG_N] && !flags[FLAG_Z];
         CC_GE:   taken =  flags[FLAG_N] ||  flags[FLAG_Z];
         CC_UC:   taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Front-end fetch/decode/execute/advance controller. Captures each fetched
// word into the IR, resolves Bcond/Jcond/JAL on leaving EXEC and drives the
// PC control inputs for exactly one cycle in ADV.
module fetch_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned DW     = 16,
   parameter int unsigned DISP_W = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] pc,
   output logic          fetch_req,
   input  logic [DW-1:0] instr,
   input  logic          instr_valid,
   input  logic [4:0]    flags,
   input  logic [DW-1:0] rtarget,
   input  logic          stall_in,
   output logic [DW-1:0] ir,
   output logic          ir_valid,
   output logic          pc_en,
   output logic [1:0]    pc_sel,
   output logic [DW-1:0] pc_imm,
   output logic [DW-1:0] pc_target,
   output logic          link_we,
   output logic [3:0]    link_addr,
   output logic [DW-1:0] link_val
);

   seq_state_e    state_q, state_d;
   logic [DW-1:0] ir_q;
   logic [1:0]    sel_q, sel_d;
   logic [DW-1:0] imm_q, imm_d;
   logic [DW-1:0] target_q, target_d;
   logic [DW-1:0] link_val_q, link_val_d;
   logic          jal_q, jal_d;

   logic          taken;
   logic          is_bcond, is_jcond, is_jal;
   logic [DW-1:0] disp_ext;

   assign is_bcond = (ir_q[15:12] == OP_BCOND);
   assign is_jcond = (ir_q[15:12] == OP_EXT) && (ir_q[7:4] == EXT_JCOND);
   assign is_jal   = (ir_q[15:12] == OP_EXT) && (ir_q[7:4] == EXT_JAL);
   assign disp_ext = {{(DW-DISP_W){ir_q[DISP_W-1]}}, ir_q[DISP_W-1:0]};

   cond_eval u_cond_eval (
      .cond  (ir_q[11:8]),
      .flags (flags),
      .taken (taken)
   );

   // State register; reset lands in IDLE from any state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state: IDLE -> FETCH -> (valid) EXEC -> (no stall) ADV -> FETCH
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = FETCH;
         FETCH:   if (instr_valid) state_d = EXEC;
         EXEC:    if (!stall_in) state_d = ADV;
         ADV:     state_d = FETCH;
         default: state_d = IDLE;
      endcase
   end

   // State-decoded strobes; all low in IDLE so reset clears them at once
   always_comb begin
      fetch_req = (state_q == FETCH);
      ir_valid  = (state_q == EXEC);
      pc_en     = (state_q == ADV);
      link_we   = (state_q == ADV) && jal_q;
   end

   // Next-PC decision from the IR and the flags/target seen this cycle
   always_comb begin
      sel_d      = SEL_DEFAULT;
      imm_d      = '0;
      target_d   = '0;
      link_val_d = '0;
      jal_d      = 1'b0;
      if (is_bcond) begin
         if (taken) begin
            sel_d = SEL_IMM;
            imm_d = disp_ext;
         end
      end else if (is_jcond) begin
         target_d = rtarget;
         if (taken) sel_d = SEL_MEM;
      end else if (is_jal) begin
         sel_d      = SEL_MEM;
         target_d   = rtarget;
         link_val_d = pc + DW'(1);
         jal_d      = 1'b1;
      end
   end

   // IR capture in FETCH; decision registered only on the EXEC exit cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ir_q       <= '0;
         sel_q      <= SEL_DEFAULT;
         imm_q      <= '0;
         target_q   <= '0;
         link_val_q <= '0;
         jal_q      <= 1'b0;
      end else begin
         if (state_q == FETCH && instr_valid) ir_q <= instr;
         if (state_q == EXEC && !stall_in) begin
            sel_q      <= sel_d;
            imm_q      <= imm_d;
            target_q   <= target_d;
            link_val_q <= link_val_d;
            jal_q      <= jal_d;
         end
      end
   end

   assign ir        = ir_q;
   assign pc_sel    = sel_q;
   assign pc_imm    = imm_q;
   assign pc_target = target_q;
   assign link_val  = link_val_q;
   assign link_addr = ir_q[11:8];

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Front-end controller that drives the program counter's control inputs (pc_en, sel, imm, mem_addr) and receives the instruction word read at the current PC.
- Runs a fetch/decode/execute/advance loop and captures each instruction into an instruction register (IR) for the datapath.
- Resolves Bcond, Jcond and JAL against the PSR flags and selects the next-PC source: 00 default +1, 01 PC+imm, 10 absolute address.

Parameters:
- DW, 16, data/instruction/address width.
- DISP_W, 8, Bcond displacement width, sign-extended to DW.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- pc  in  DW  current PC count, used for the link value
- fetch_req  out  1  high while awaiting the instruction word
- instr  in  DW  instruction memory read data
- instr_valid  in  1  instr is valid this cycle
- flags  in  5  PSR {C,L,F,Z,N}, bit4=C … bit0=N
- rtarget  in  DW  register-file value addressed by instr[3:0]
- stall_in  in  1  execute stage busy; hold the current instruction
- ir  out  DW  instruction register
- ir_valid  out  1  ir holds an instruction in execute
- pc_en  out  1  one-cycle PC advance strobe
- pc_sel  out  2  next-PC source; zero-extend when driving a wider PC select input
- pc_imm  out  DW  sign-extended displacement
- pc_target  out  DW  absolute jump target
- link_we  out  1  one-cycle write of the link register
- link_addr  out  4  link register index, instr[11:8]
- link_val  out  DW  pc+1

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All outputs are 0: ir=0, pc_sel=00, pc_imm=0, pc_target=0, link_val=0.
- States:
  - IDLE: exits to FETCH after one cycle.
  - FETCH: fetch_req=1. On instr_valid, ir<=instr and go to EXEC. Otherwise stay; there is no timeout.
  - EXEC: ir_valid=1. Stay while stall_in=1. On the first cycle with stall_in=0:
    - register the next-PC decision, pc_imm, pc_target and link signals;
    - go to ADV.
  - ADV: pc_en=1 with the registered pc_sel, pc_imm and pc_target; link_we pulses for a taken JAL. Next state is FETCH.
- Throughput: minimum 3 cycles per instruction (FETCH with instr_valid, EXEC, ADV). pc_en is never high outside ADV.
- Decode:
  - Bcond: ir[15:12]=1100, cond=ir[11:8]. pc_imm = sign-extend(ir[7:0]). Taken → sel 01.
  - Jcond: ir[15:12]=0100 and ir[7:4]=1100. pc_target=rtarget. Taken → sel 10.
  - JAL: ir[15:12]=0100 and ir[7:4]=1000. Always taken → sel 10, pc_target=rtarget, link_val=pc+1 (mod 2^16), link_we=1 in ADV.
  - Not taken, or any other opcode: sel 00, pc_imm=0.
- Conditions (combinational cond_eval):
  - EQ 0000: Z
  - NE 0001: !Z
  - CS 0010: C
  - CC 0011: !C
  - HI 0100: L
  - LS 0101: !L
  - GT 0110: N
  - LE 0111: !N
  - FS 1000: F
  - FC 1001: !F
  - LO 1010: !L&!Z
  - HS 1011: L|Z
  - LT 1100: !N&!Z
  - GE 1101: N|Z
  - UC 1110: 1
  - 1111: never taken
- Sampling: flags and rtarget are sampled only on the EXEC exit cycle. Changes during stall cycles have no effect.
- Boundaries:
  - instr_valid outside FETCH is ignored.
  - stall_in outside EXEC is ignored.
  - Displacement 0x80 gives pc_imm=0xFF80; PC wrap is modulo 2^16.
  - pc=0xFFFF gives link_val=0x0000.
  - Reset asserted in ADV suppresses pc_en and link_we the same instant.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_BCOND=4'hC, OP_EXT=4'h4, EXT_JCOND=4'hC, EXT_JAL=4'h8;
  - the 15 condition code constants;
  - PC select constants SEL_DEFAULT=2'b00, SEL_IMM=2'b01, SEL_MEM=2'b10;
  - state encodings IDLE, FETCH, EXEC, ADV;
  - flag bit indices.
- One sub-module, cond_eval (cond[3:0], flags[4:0] → taken), reused later by the ALU's Scond.

Test Plan:
- Reset, then instr=0x0000 with instr_valid at first FETCH and stall_in=0 → pc_en one cycle, pc_sel=00, ir=0x0000; ir_valid high exactly one cycle.
- ir=0xC0FC (BEQ −4), Z=1 → pc_sel=01, pc_imm=0xFFFC. Same instruction with Z=0 → pc_sel=00.
- ir=0x4EC3 (JUC r3), rtarget=0x1234 → pc_sel=10, pc_target=0x1234, link_we=0.
- ir=0x4A85 (JAL r10,r5), pc=0x0041, rtarget=0x0200 → pc_sel=10, pc_target=0x0200, link_addr=0xA, link_val=0x0042, link_we with pc_en.
- BEQ with stall_in high 4 cycles while Z toggles, Z=1 at release → taken. pc_en only after release; ir_valid high 5 cycles.
- rst low during ADV → pc_en=0 immediately, all outputs 0; after rst high, IDLE then FETCH.
